// File: rtl/id_issue_queue_pkg.sv
// ============================================================================
// Module : id_issue_queue_pkg
// Brief  : Shared widths for the IF/ID issue-queue slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package id_issue_queue_pkg;

    localparam int XLEN       = 64;
    localparam int FETCH_W    = 64;
    localparam int INST_W     = 32;
    localparam int REG_ADDR_W = 5;

    // One queue entry is {pc, fetch word, upper vector bits}.
    function automatic int qe_width(input int xlen, input int fetch_w);
        return xlen + fetch_w + INST_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_haz_scoreboard.sv
// ============================================================================
// Module : id_haz_scoreboard
// Brief  : Tracks in-flight long-latency writers and flags a RAW hazard on the head.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_haz_scoreboard #(
    parameter int HAZ_DEPTH = 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      i_flush,
    input  logic                                      i_d_ready,
    input  logic                                      i_d_valid,
    input  logic                                      i_issue,
    input  logic [id_issue_queue_pkg::REG_ADDR_W-1:0] i_rs1,
    input  logic [id_issue_queue_pkg::REG_ADDR_W-1:0] i_rs2,
    input  logic                                      i_rs1_en,
    input  logic                                      i_rs2_en,
    input  logic                                      i_rf_we,
    input  logic [id_issue_queue_pkg::REG_ADDR_W-1:0] i_rf_waddr,
    input  logic                                      i_long,
    output logic                                      o_stallreq
);
    import id_issue_queue_pkg::*;

    logic [HAZ_DEPTH-1:0]                 r_v;
    logic [HAZ_DEPTH-1:0][REG_ADDR_W-1:0] r_waddr;
    logic                                 w_new_v;
    logic                                 w_hit;

    assign w_new_v = i_issue & i_rf_we & i_long & (i_rf_waddr != '0);

    // Slots only move when EX advances; an idle EX cycle shifts in a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_v     <= '0;
            r_waddr <= '0;
        end else if (i_d_ready) begin
            r_v[0]     <= w_new_v;
            r_waddr[0] <= i_rf_waddr;
            for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
                r_v[i]     <= r_v[i-1];
                r_waddr[i] <= r_waddr[i-1];
            end
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (r_v[i] &&
                ((i_rs1_en && (i_rs1 == r_waddr[i]) && (i_rs1 != '0)) ||
                 (i_rs2_en && (i_rs2 == r_waddr[i]) && (i_rs2 != '0))))
                w_hit = 1'b1;
        end
    end

    assign o_stallreq = i_d_valid & w_hit;

endmodule

`default_nettype wire

// File: rtl/id_issue_queue.sv
// ============================================================================
// Module : id_issue_queue
// Brief  : Fetch-to-decode instruction queue with long-latency hazard stall.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_issue_queue #(
    parameter int XLEN      = id_issue_queue_pkg::XLEN,
    parameter int FETCH_W   = id_issue_queue_pkg::FETCH_W,
    parameter int DEPTH     = 4,
    parameter int HAZ_DEPTH = 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      flush,
    input  logic                                      f_valid,
    output logic                                      f_ready,
    input  logic [XLEN-1:0]                           f_pc,
    input  logic [FETCH_W-1:0]                        f_data,
    input  logic [31:0]                               f_csr_vec_h,
    output logic                                      d_valid,
    input  logic                                      d_ready,
    output logic [XLEN-1:0]                           d_pc,
    output logic [31:0]                               d_inst,
    output logic [31:0]                               d_csr_vec_h,
    input  logic [id_issue_queue_pkg::REG_ADDR_W-1:0] dec_rs1,
    input  logic [id_issue_queue_pkg::REG_ADDR_W-1:0] dec_rs2,
    input  logic                                      dec_rs1_en,
    input  logic                                      dec_rs2_en,
    input  logic                                      dec_rf_we,
    input  logic [id_issue_queue_pkg::REG_ADDR_W-1:0] dec_rf_waddr,
    input  logic                                      dec_long,
    output logic                                      stallreq_id,
    output logic                                      issue,
    output logic [$clog2(DEPTH):0]                    q_count
);
    import id_issue_queue_pkg::*;

    localparam int AW   = $clog2(DEPTH);
    localparam int QE_W = qe_width(XLEN, FETCH_W);

    logic [QE_W-1:0]    r_mem [DEPTH];
    logic [AW:0]        r_wr;
    logic [AW:0]        r_rd;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [QE_W-1:0]    w_head;
    logic [XLEN-1:0]    w_head_pc;
    logic [FETCH_W-1:0] w_head_data;
    logic [31:0]        w_head_vec;
    logic [INST_W-1:0]  w_inst;

    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_empty = (r_wr == r_rd);
    assign w_push  = f_valid & f_ready & ~flush;
    assign w_pop   = issue;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + (AW+1)'(1);
            if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr[AW-1:0]] <= {f_pc, f_data, f_csr_vec_h};
    end

    assign w_head      = r_mem[r_rd[AW-1:0]];
    assign w_head_pc   = w_head[QE_W-1 -: XLEN];
    assign w_head_data = w_head[INST_W +: FETCH_W];
    assign w_head_vec  = w_head[INST_W-1:0];

    generate
        if (FETCH_W == INST_W) begin : g_single_word
            assign w_inst = w_head_data[INST_W-1:0];
        end else begin : g_word_select
            localparam int WI = $clog2(FETCH_W / INST_W);
            logic [WI-1:0] w_idx;
            assign w_idx  = w_head_pc[WI+1:2];
            assign w_inst = w_head_data[w_idx*INST_W +: INST_W];
        end
    endgenerate

    // Outputs are zeroed while empty so the decoder sees a clean bubble.
    assign f_ready     = ~w_full;
    assign d_valid     = ~w_empty;
    assign d_pc        = d_valid ? w_head_pc  : '0;
    assign d_inst      = d_valid ? w_inst     : '0;
    assign d_csr_vec_h = d_valid ? w_head_vec : '0;
    assign issue       = d_valid & d_ready & ~stallreq_id;
    assign q_count     = r_wr - r_rd;

    id_haz_scoreboard #(
        .HAZ_DEPTH (HAZ_DEPTH)
    ) u_haz (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (flush),
        .i_d_ready  (d_ready),
        .i_d_valid  (d_valid),
        .i_issue    (issue),
        .i_rs1      (dec_rs1),
        .i_rs2      (dec_rs2),
        .i_rs1_en   (dec_rs1_en),
        .i_rs2_en   (dec_rs2_en),
        .i_rf_we    (dec_rf_we),
        .i_rf_waddr (dec_rf_waddr),
        .i_long     (dec_long),
        .o_stallreq (stallreq_id)
    );

endmodule

`default_nettype wire

// File: tb/tb_id_issue_queue.sv
// ============================================================================
// Module : tb_id_issue_queue
// Brief  : Directed bench for id_issue_queue (HAZ_DEPTH=1 and HAZ_DEPTH=2 copies).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_issue_queue;

    typedef struct packed {
        logic       rs1_en;
        logic       rs2_en;
        logic       we;
        logic       lng;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } dec_t;

    // Small RV decoder standing in for decoder_64i.
    function automatic dec_t decode(input logic [31:0] inst);
        dec_t d;
        d        = '0;
        d.rs1    = inst[19:15];
        d.rs2    = inst[24:20];
        d.rd     = inst[11:7];
        case (inst[6:0])
            7'b0000011: begin d.rs1_en = 1'b1; d.we = 1'b1; d.lng = 1'b1; end
            7'b0010011: begin d.rs1_en = 1'b1; d.we = 1'b1; end
            7'b0110011: begin d.rs1_en = 1'b1; d.rs2_en = 1'b1; d.we = 1'b1; end
            7'b0110111: begin d.we = 1'b1; end
            default:    ;
        endcase
        return d;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n, flush, f_valid, d_ready;
    logic [63:0] f_pc, f_data;
    logic [31:0] f_csr_vec_h;

    logic        f_ready1, d_valid1, stall1, issue1;
    logic [63:0] d_pc1;
    logic [31:0] d_inst1, d_vec1;
    logic [2:0]  q_count1;
    dec_t        dec1;

    logic        f_ready2, d_valid2, stall2, issue2;
    logic [63:0] d_pc2;
    logic [31:0] d_inst2, d_vec2;
    logic [2:0]  q_count2;
    dec_t        dec2;

    int n_vec = 0;
    int n_err = 0;

    assign dec1 = decode(d_inst1);
    assign dec2 = decode(d_inst2);

    always #5 clk = ~clk;

    id_issue_queue #(.XLEN(64), .FETCH_W(64), .DEPTH(4), .HAZ_DEPTH(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .f_valid(f_valid), .f_ready(f_ready1),
        .f_pc(f_pc), .f_data(f_data), .f_csr_vec_h(f_csr_vec_h), .d_valid(d_valid1),
        .d_ready(d_ready), .d_pc(d_pc1), .d_inst(d_inst1), .d_csr_vec_h(d_vec1),
        .dec_rs1(dec1.rs1), .dec_rs2(dec1.rs2), .dec_rs1_en(dec1.rs1_en),
        .dec_rs2_en(dec1.rs2_en), .dec_rf_we(dec1.we), .dec_rf_waddr(dec1.rd),
        .dec_long(dec1.lng), .stallreq_id(stall1), .issue(issue1), .q_count(q_count1)
    );

    id_issue_queue #(.XLEN(64), .FETCH_W(64), .DEPTH(4), .HAZ_DEPTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .f_valid(f_valid), .f_ready(f_ready2),
        .f_pc(f_pc), .f_data(f_data), .f_csr_vec_h(f_csr_vec_h), .d_valid(d_valid2),
        .d_ready(d_ready), .d_pc(d_pc2), .d_inst(d_inst2), .d_csr_vec_h(d_vec2),
        .dec_rs1(dec2.rs1), .dec_rs2(dec2.rs2), .dec_rs1_en(dec2.rs1_en),
        .dec_rs2_en(dec2.rs2_en), .dec_rf_we(dec2.we), .dec_rf_waddr(dec2.rd),
        .dec_long(dec2.lng), .stallreq_id(stall2), .issue(issue2), .q_count(q_count2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push2(input logic [31:0] a, input logic [31:0] b, input logic [63:0] pc);
        d_ready = 1'b0;
        f_valid = 1'b1;
        f_pc    = pc;
        f_data  = {a, a};
        tick();
        f_pc    = pc + 64'd4;
        f_data  = {b, b};
        tick();
        f_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush   = 1'b1;
        d_ready = 1'b0;
        f_valid = 1'b0;
        tick();
        flush   = 1'b0;
    endtask

    localparam logic [31:0] LW_X5   = 32'h0000A283;  // lw   x5,0(x1)
    localparam logic [31:0] LW_X0   = 32'h0000A003;  // lw   x0,0(x1)
    localparam logic [31:0] ADDI_X5 = 32'h00128313;  // addi x6,x5,1
    localparam logic [31:0] ADDI_X0 = 32'h00100313;  // addi x6,x0,1
    localparam logic [31:0] LUI_X6  = 32'h00028337;  // lui  x6 (rs1 field = 5)
    localparam logic [31:0] ADD_RS2 = 32'h005083B3;  // add  x7,x1,x5

    initial begin
        logic [31:0] exp_word;

        rst_n = 1'b0; flush = 1'b0; f_valid = 1'b0; d_ready = 1'b0;
        f_pc = '0; f_data = '0; f_csr_vec_h = '0;
        tick(); tick();
        rst_n = 1'b1;
        #2;
        chk("rst_d_valid", d_valid1, 0);
        chk("rst_f_ready", f_ready1, 1);
        chk("rst_q_count", q_count1, 0);
        chk("rst_d_pc",    d_pc1,    0);
        chk("rst_d_inst",  d_inst1,  0);
        chk("rst_d_vec",   d_vec1,   0);
        chk("rst_stall",   stall1,   0);
        chk("rst_issue",   issue1,   0);

        // Fill the queue with EX stalled.
        for (int i = 0; i < 4; i++) begin
            f_valid     = 1'b1;
            f_pc        = 64'h8000_0000 + 64'(4 * i);
            f_data      = 64'h11111111_22222222;
            f_csr_vec_h = 32'hC0DE_0000 | 32'(i);
            tick();
            if (i == 0) begin
                #2;
                chk("first_push_d_valid", d_valid1, 1);
                chk("first_push_q_count", q_count1, 1);
            end
        end
        f_pc = 64'h8000_0010;
        #2;
        chk("full_f_ready", f_ready1, 0);
        chk("full_q_count", q_count1, 4);
        chk("full_d_pc",    d_pc1,    64'h8000_0000);
        chk("head_word0",   d_inst1,  32'h22222222);
        chk("head_vec",     d_vec1,   32'hC0DE_0000);

        // Pop while full with a packet offered: no pass-through.
        d_ready = 1'b1;
        #2;
        chk("full_pop_issue",   issue1,   1);
        chk("full_pop_f_ready", f_ready1, 0);
        tick();
        d_ready = 1'b0;
        #2;
        chk("no_passthru_q_count", q_count1, 3);
        chk("pop_d_pc",            d_pc1,    64'h8000_0004);
        chk("head_word1",          d_inst1,  32'h11111111);

        // Refill, then flush with a packet offered in the same cycle.
        tick();
        #2;
        chk("refill_q_count", q_count1, 4);
        f_pc  = 64'h8000_0014;
        flush = 1'b1;
        tick();
        flush = 1'b0; f_valid = 1'b0;
        #2;
        chk("flush_q_count", q_count1, 0);
        chk("flush_d_valid", d_valid1, 0);
        chk("flush_d_inst",  d_inst1,  0);
        chk("flush_d_pc",    d_pc1,    0);
        chk("flush_f_ready", f_ready1, 1);

        // Load x5 followed by a consumer of x5.
        push2(LW_X5, ADDI_X5, 64'h8000_0100);
        d_ready = 1'b1;
        #2;
        chk("haz_t0_issue1", issue1, 1);
        chk("haz_t0_stall1", stall1, 0);
        chk("haz_t0_issue2", issue2, 1);
        tick(); #2;
        chk("haz_t1_stall1", stall1, 1);
        chk("haz_t1_issue1", issue1, 0);
        chk("haz_t1_stall2", stall2, 1);
        tick(); #2;
        chk("haz_t2_stall1", stall1, 0);
        chk("haz_t2_issue1", issue1, 1);
        chk("haz_t2_stall2", stall2, 1);
        chk("haz_t2_issue2", issue2, 0);
        tick(); #2;
        chk("haz_t3_valid1", d_valid1, 0);
        chk("haz_t3_stall2", stall2, 0);
        chk("haz_t3_issue2", issue2, 1);
        tick();

        // Consumer that does not read rs1 (field happens to be 5).
        push2(LW_X5, LUI_X6, 64'h8000_0110);
        d_ready = 1'b1;
        #2;
        chk("lui_t0_issue1", issue1, 1);
        tick(); #2;
        chk("lui_t1_stall1", stall1, 0);
        chk("lui_t1_issue1", issue1, 1);
        chk("lui_t1_stall2", stall2, 0);
        tick();

        // Load to x0 never blocks.
        push2(LW_X0, ADDI_X0, 64'h8000_0120);
        d_ready = 1'b1;
        #2;
        chk("x0_t0_issue1", issue1, 1);
        tick(); #2;
        chk("x0_t1_stall1", stall1, 0);
        chk("x0_t1_issue1", issue1, 1);
        chk("x0_t1_stall2", stall2, 0);
        tick();

        // Hazard through rs2.
        push2(LW_X5, ADD_RS2, 64'h8000_0130);
        d_ready = 1'b1;
        #2;
        chk("rs2_t0_issue1", issue1, 1);
        tick(); #2;
        chk("rs2_t1_stall1", stall1, 1);
        tick(); #2;
        chk("rs2_t2_issue1", issue1, 1);
        chk("rs2_t2_stall2", stall2, 1);
        tick(); #2;
        chk("rs2_t3_issue2", issue2, 1);
        tick();

        // EX stalled: slot holds; then flush must clear it.
        push2(LW_X5, ADDI_X5, 64'h8000_0140);
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("hold_stall1", stall1, 1);
            tick();
        end
        do_flush();
        f_valid = 1'b1;
        f_pc    = 64'h8000_0200;
        f_data  = {ADDI_X5, ADDI_X5};
        tick();
        f_valid = 1'b0;
        #2;
        chk("sb_flush_valid1", d_valid1, 1);
        chk("sb_flush_stall1", stall1,   0);
        do_flush();

        // Ten packets through with two resident: exercises pointer wrap.
        for (int i = 0; i < 2; i++) begin
            f_valid = 1'b1;
            f_pc    = 64'h9000_0000 + 64'(8 * i);
            f_data  = {32'hAAAA_0000 + 32'(i << 4), 32'h5555_0000 + 32'(i << 4)};
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                f_valid = 1'b1;
                f_pc    = 64'h9000_0000 + 64'(8 * (k + 2));
                f_data  = {32'hAAAA_0000 + 32'((k + 2) << 4), 32'h5555_0000 + 32'((k + 2) << 4)};
            end else begin
                f_valid = 1'b0;
            end
            d_ready  = 1'b1;
            exp_word = 32'h5555_0000 + 32'(k << 4);
            #2;
            chk("wrap_inst",  d_inst1, exp_word);
            chk("wrap_issue", issue1,  1);
            if (k < 8) chk("wrap_q_count", q_count1, 2);
            tick();
        end
        d_ready = 1'b0;
        #2;
        chk("drain_valid", d_valid1, 0);
        chk("drain_count", q_count1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
